// File: rtl/rtsnoc_pkg.sv
// Shared definitions for the RTSNoC bridges: flit header geometry, command word
// layout, error data word and the AXI-master FSM encoding.
package rtsnoc_pkg;

  localparam int DATA_W        = 32;
  localparam int LOCAL_W       = 3;
  localparam int CMD_WE_BIT    = 31;
  localparam int CMD_WSTRB_LSB = 24;
  localparam int CMD_ADDR_W    = 24;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic                  we;
    logic [3:0]            wstrb;
    logic [CMD_ADDR_W-1:0] word_addr;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE, CMD, WDATA, AW_W, B, AR, R, RESP
  } state_t;

  function automatic int hdr_size(int sx, int sy);
    return 2*sx + 2*sy + 2*LOCAL_W;
  endfunction

  // Field LSB offsets, flit is {src_x, src_y, src_local, dst_x, dst_y, dst_local, data}.
  function automatic int dst_local_lsb();
    return DATA_W;
  endfunction
  function automatic int dst_y_lsb();
    return DATA_W + LOCAL_W;
  endfunction
  function automatic int dst_x_lsb(int sy);
    return DATA_W + LOCAL_W + sy;
  endfunction
  function automatic int src_local_lsb(int sx, int sy);
    return DATA_W + LOCAL_W + sx + sy;
  endfunction
  function automatic int src_y_lsb(int sx, int sy);
    return DATA_W + 2*LOCAL_W + sx + sy;
  endfunction
  function automatic int src_x_lsb(int sx, int sy);
    return DATA_W + 2*LOCAL_W + sx + 2*sy;
  endfunction

endpackage

// File: rtl/rtsnoc_flit_codec.sv
// Combinational pack/unpack of an RTSNoC flit into header fields and data.
module rtsnoc_flit_codec
  import rtsnoc_pkg::*;
#(
  parameter int SOC_SIZE_X = 1,
  parameter int SOC_SIZE_Y = 1,
  localparam int BUS_W = hdr_size(SOC_SIZE_X, SOC_SIZE_Y) + DATA_W
) (
  input  logic [SOC_SIZE_X-1:0] pack_src_x,
  input  logic [SOC_SIZE_Y-1:0] pack_src_y,
  input  logic [LOCAL_W-1:0]    pack_src_local,
  input  logic [SOC_SIZE_X-1:0] pack_dst_x,
  input  logic [SOC_SIZE_Y-1:0] pack_dst_y,
  input  logic [LOCAL_W-1:0]    pack_dst_local,
  input  logic [DATA_W-1:0]     pack_data,
  output logic [BUS_W-1:0]      flit_o,
  input  logic [BUS_W-1:0]      flit_i,
  output logic [SOC_SIZE_X-1:0] unpack_src_x,
  output logic [SOC_SIZE_Y-1:0] unpack_src_y,
  output logic [LOCAL_W-1:0]    unpack_src_local,
  output logic [SOC_SIZE_X-1:0] unpack_dst_x,
  output logic [SOC_SIZE_Y-1:0] unpack_dst_y,
  output logic [LOCAL_W-1:0]    unpack_dst_local,
  output logic [DATA_W-1:0]     unpack_data
);

  assign flit_o = {pack_src_x, pack_src_y, pack_src_local,
                   pack_dst_x, pack_dst_y, pack_dst_local, pack_data};

  assign unpack_src_x     = flit_i[src_x_lsb(SOC_SIZE_X, SOC_SIZE_Y)     +: SOC_SIZE_X];
  assign unpack_src_y     = flit_i[src_y_lsb(SOC_SIZE_X, SOC_SIZE_Y)     +: SOC_SIZE_Y];
  assign unpack_src_local = flit_i[src_local_lsb(SOC_SIZE_X, SOC_SIZE_Y) +: LOCAL_W];
  assign unpack_dst_x     = flit_i[dst_x_lsb(SOC_SIZE_Y)                 +: SOC_SIZE_X];
  assign unpack_dst_y     = flit_i[dst_y_lsb()                           +: SOC_SIZE_Y];
  assign unpack_dst_local = flit_i[dst_local_lsb()                       +: LOCAL_W];
  assign unpack_data      = flit_i[DATA_W-1:0];

endmodule

// File: rtl/rtsnoc_to_axi4lite_master.sv
// RTSNoC port to AXI4-Lite master bridge: one AXI read or write per request
// flit, answered by exactly one response flit to the requesting node.
module rtsnoc_to_axi4lite_master
  import rtsnoc_pkg::*;
#(
  parameter int          NOC_DATA_WIDTH = 32,
  parameter int          NOC_LOCAL_ADR  = 0,
  parameter int          NOC_X          = 0,
  parameter int          NOC_Y          = 0,
  parameter int          SOC_SIZE_X     = 1,
  parameter int          SOC_SIZE_Y     = 1,
  parameter logic [31:0] AXI_BASE_ADDR  = 32'h0000_0000,
  localparam int NOC_BUS_SIZE = hdr_size(SOC_SIZE_X, SOC_SIZE_Y) + NOC_DATA_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  output logic [NOC_BUS_SIZE-1:0] noc_din_o,
  output logic                    noc_wr_o,
  output logic                    noc_rd_o,
  input  logic [NOC_BUS_SIZE-1:0] noc_dout_i,
  input  logic                    noc_wait_i,
  input  logic                    noc_nd_i,
  output logic [31:0]             axi_awaddr_o,
  output logic                    axi_awvalid_o,
  input  logic                    axi_awready_i,
  output logic [31:0]             axi_wdata_o,
  output logic [3:0]              axi_wstrb_o,
  output logic                    axi_wvalid_o,
  input  logic                    axi_wready_i,
  input  logic [1:0]              axi_bresp_i,
  input  logic                    axi_bvalid_i,
  output logic                    axi_bready_o,
  output logic [31:0]             axi_araddr_o,
  output logic                    axi_arvalid_o,
  input  logic                    axi_arready_i,
  input  logic [31:0]             axi_rdata_i,
  input  logic [1:0]              axi_rresp_i,
  input  logic                    axi_rvalid_i,
  output logic                    axi_rready_o
);

  localparam logic [SOC_SIZE_X-1:0] OWN_X     = SOC_SIZE_X'(NOC_X);
  localparam logic [SOC_SIZE_Y-1:0] OWN_Y     = SOC_SIZE_Y'(NOC_Y);
  localparam logic [LOCAL_W-1:0]    OWN_LOCAL = LOCAL_W'(NOC_LOCAL_ADR);

  state_t                  state_q, state_d;
  logic [SOC_SIZE_X-1:0]   src_x_q, src_x_d;
  logic [SOC_SIZE_Y-1:0]   src_y_q, src_y_d;
  logic [LOCAL_W-1:0]      src_local_q, src_local_d;
  cmd_t                    cmd_q, cmd_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             resp_q, resp_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;

  logic [SOC_SIZE_X-1:0]   in_src_x, in_dst_x;
  logic [SOC_SIZE_Y-1:0]   in_src_y, in_dst_y;
  logic [LOCAL_W-1:0]      in_src_local, in_dst_local;
  logic [31:0]             in_data;
  logic [NOC_BUS_SIZE-1:0] resp_flit;
  cmd_t                    in_cmd;
  logic                    same_src;
  logic [31:0]             axi_addr;
  logic                    rd;
  logic                    unused_bits;

  rtsnoc_flit_codec #(
    .SOC_SIZE_X (SOC_SIZE_X),
    .SOC_SIZE_Y (SOC_SIZE_Y)
  ) u_codec (
    .pack_src_x       (OWN_X),
    .pack_src_y       (OWN_Y),
    .pack_src_local   (OWN_LOCAL),
    .pack_dst_x       (src_x_q),
    .pack_dst_y       (src_y_q),
    .pack_dst_local   (src_local_q),
    .pack_data        (resp_q),
    .flit_o           (resp_flit),
    .flit_i           (noc_dout_i),
    .unpack_src_x     (in_src_x),
    .unpack_src_y     (in_src_y),
    .unpack_src_local (in_src_local),
    .unpack_dst_x     (in_dst_x),
    .unpack_dst_y     (in_dst_y),
    .unpack_dst_local (in_dst_local),
    .unpack_data      (in_data)
  );

  // The router only delivers flits addressed to this port, so dst is not re-checked.
  assign unused_bits = ^{in_dst_x, in_dst_y, in_dst_local, axi_rresp_i[0]};

  assign in_cmd   = '{we:        in_data[CMD_WE_BIT],
                      wstrb:     in_data[CMD_WSTRB_LSB +: 4],
                      word_addr: in_data[CMD_ADDR_W-1:0]};
  assign same_src = {in_src_x, in_src_y, in_src_local} == {src_x_q, src_y_q, src_local_q};
  assign axi_addr = AXI_BASE_ADDR + {6'b0, cmd_q.word_addr, 2'b00};
  assign noc_rd_o = rd & rst_n_i;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    state_d       = state_q;
    src_x_d       = src_x_q;
    src_y_d       = src_y_q;
    src_local_d   = src_local_q;
    cmd_d         = cmd_q;
    wdata_d       = wdata_q;
    resp_d        = resp_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    rd            = 1'b0;
    noc_wr_o      = 1'b0;
    noc_din_o     = '0;
    axi_awaddr_o  = '0;
    axi_awvalid_o = 1'b0;
    axi_wdata_o   = '0;
    axi_wstrb_o   = '0;
    axi_wvalid_o  = 1'b0;
    axi_bready_o  = 1'b0;
    axi_araddr_o  = '0;
    axi_arvalid_o = 1'b0;
    axi_rready_o  = 1'b0;

    unique case (state_q)
      IDLE: if (noc_nd_i) begin
        rd          = 1'b1;
        src_x_d     = in_src_x;
        src_y_d     = in_src_y;
        src_local_d = in_src_local;
        cmd_d       = in_cmd;
        state_d     = CMD;
      end
      CMD: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = cmd_q.we ? WDATA : AR;
      end
      WDATA: if (noc_nd_i) begin
        rd = 1'b1;
        if (same_src) begin
          wdata_d = in_data;
          state_d = AW_W;
        end else begin
          // A foreign flit here is a fresh request; the pending write is dropped.
          src_x_d     = in_src_x;
          src_y_d     = in_src_y;
          src_local_d = in_src_local;
          cmd_d       = in_cmd;
          state_d     = CMD;
        end
      end
      AW_W: begin
        axi_awaddr_o  = axi_addr;
        axi_wdata_o   = wdata_q;
        axi_wstrb_o   = cmd_q.wstrb;
        axi_awvalid_o = !aw_done_q;
        axi_wvalid_o  = !w_done_q;
        if (axi_awvalid_o && axi_awready_i) aw_done_d = 1'b1;
        if (axi_wvalid_o && axi_wready_i)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)          state_d   = B;
      end
      B: begin
        axi_bready_o = 1'b1;
        if (axi_bvalid_i) begin
          resp_d  = {30'b0, axi_bresp_i};
          state_d = RESP;
        end
      end
      AR: begin
        axi_araddr_o  = axi_addr;
        axi_arvalid_o = 1'b1;
        if (axi_arready_i) state_d = R;
      end
      R: begin
        axi_rready_o = 1'b1;
        if (axi_rvalid_i) begin
          resp_d  = axi_rresp_i[1] ? ERR_DATA : axi_rdata_i;
          state_d = RESP;
        end
      end
      RESP: begin
        noc_wr_o  = 1'b1;
        noc_din_o = resp_flit;
        if (!noc_wait_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state uses non-blocking assignments; the reset is synchronous, so it is tested inside the clocked block.
    if (!rst_n_i) begin
      state_q     <= IDLE;
      src_x_q     <= '0;
      src_y_q     <= '0;
      src_local_q <= '0;
      cmd_q       <= '0;
      wdata_q     <= '0;
      resp_q      <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_x_q     <= src_x_d;
      src_y_q     <= src_y_d;
      src_local_q <= src_local_d;
      cmd_q       <= cmd_d;
      wdata_q     <= wdata_d;
      resp_q      <= resp_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
    end
  end

endmodule

// File: tb/tb_rtsnoc_to_axi4lite_master.sv
// Scoreboard bench: stimulus pushes expected AXI beats and response flits,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_rtsnoc_to_axi4lite_master;

  localparam int BUS = 42;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [BUS-1:0]  noc_din, noc_dout;
  logic            noc_wr, noc_rd, noc_wait, noc_nd;
  logic [31:0]     axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
  logic [3:0]      axi_wstrb;
  logic            axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic [1:0]      axi_bresp, axi_rresp;
  logic            axi_bvalid, axi_bready, axi_arvalid, axi_arready;
  logic            axi_rvalid, axi_rready;

  always #5 clk = ~clk;

  rtsnoc_to_axi4lite_master #(
    .NOC_DATA_WIDTH (32),
    .NOC_LOCAL_ADR  (0),
    .NOC_X          (0),
    .NOC_Y          (0),
    .SOC_SIZE_X     (1),
    .SOC_SIZE_Y     (1),
    .AXI_BASE_ADDR  (32'h0000_0000)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .noc_din_o     (noc_din),
    .noc_wr_o      (noc_wr),
    .noc_rd_o      (noc_rd),
    .noc_dout_i    (noc_dout),
    .noc_wait_i    (noc_wait),
    .noc_nd_i      (noc_nd),
    .axi_awaddr_o  (axi_awaddr),
    .axi_awvalid_o (axi_awvalid),
    .axi_awready_i (axi_awready),
    .axi_wdata_o   (axi_wdata),
    .axi_wstrb_o   (axi_wstrb),
    .axi_wvalid_o  (axi_wvalid),
    .axi_wready_i  (axi_wready),
    .axi_bresp_i   (axi_bresp),
    .axi_bvalid_i  (axi_bvalid),
    .axi_bready_o  (axi_bready),
    .axi_araddr_o  (axi_araddr),
    .axi_arvalid_o (axi_arvalid),
    .axi_arready_i (axi_arready),
    .axi_rdata_i   (axi_rdata),
    .axi_rresp_i   (axi_rresp),
    .axi_rvalid_i  (axi_rvalid),
    .axi_rready_o  (axi_rready)
  );

  typedef struct {
    logic [BUS-1:0] flit;
    int             cycles;
  } resp_exp_t;

  logic [31:0] exp_aw_q[$];
  logic [31:0] exp_ar_q[$];
  logic [35:0] exp_w_q[$];
  resp_exp_t   exp_resp_q[$];

  int checks = 0;
  int errors = 0;

  int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0, wait_cfg = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = '0;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, wait_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Request to this port (0,0,0) from node (x,y,l).
  function automatic logic [BUS-1:0] req_flit(input logic x, input logic y,
                                               input logic [2:0] l, input logic [31:0] d);
    return {x, y, l, 1'b0, 1'b0, 3'd0, d};
  endfunction

  // Response from this port (0,0,0) back to node (x,y,l).
  function automatic logic [BUS-1:0] resp_flit(input logic x, input logic y,
                                                input logic [2:0] l, input logic [31:0] d);
    return {1'b0, 1'b0, 3'd0, x, y, l, d};
  endfunction

  // AXI slave and NoC back-pressure models; all inputs change 1 time unit after posedge.
  always @(posedge clk) begin
    #1;
    if (!rst_n || !axi_awvalid) begin axi_awready = 1'b0; aw_cnt = 0; end
    else if (!axi_awready) begin
      if (aw_cnt >= aw_delay) axi_awready = 1'b1; else aw_cnt++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n || !axi_wvalid) begin axi_wready = 1'b0; w_cnt = 0; end
    else if (!axi_wready) begin
      if (w_cnt >= w_delay) axi_wready = 1'b1; else w_cnt++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n || !axi_arvalid) begin axi_arready = 1'b0; ar_cnt = 0; end
    else if (!axi_arready) begin
      if (ar_cnt >= ar_delay) axi_arready = 1'b1; else ar_cnt++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n || !axi_bready) begin axi_bvalid = 1'b0; axi_bresp = 2'b00; b_cnt = 0; end
    else if (!axi_bvalid) begin
      if (b_cnt >= b_delay) begin axi_bvalid = 1'b1; axi_bresp = bresp_cfg; end
      else b_cnt++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n || !axi_rready) begin
      axi_rvalid = 1'b0; axi_rdata = '0; axi_rresp = 2'b00; r_cnt = 0;
    end else if (!axi_rvalid) begin
      if (r_cnt >= r_delay) begin
        axi_rvalid = 1'b1; axi_rdata = rdata_cfg; axi_rresp = rresp_cfg;
      end else r_cnt++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n || !noc_wr) begin noc_wait = 1'b0; wait_cnt = 0; end
    else if (wait_cnt < wait_cfg) begin noc_wait = 1'b1; wait_cnt++; end
    else noc_wait = 1'b0;
  end

  // Monitor: a handshake seen at negedge completes on the following posedge.
  int        wr_cycles = 0;
  resp_exp_t cur;
  always @(negedge clk) begin
    if (rst_n) begin
      if (axi_awvalid && axi_awready) begin
        if (exp_aw_q.size() == 0) check("unexpected_aw", {32'h0, axi_awaddr}, 64'h0);
        else check("awaddr", {32'h0, axi_awaddr}, {32'h0, exp_aw_q.pop_front()});
      end
      if (axi_wvalid && axi_wready) begin
        if (exp_w_q.size() == 0) check("unexpected_w", {28'h0, axi_wstrb, axi_wdata}, 64'h0);
        else check("wstrb_wdata", {28'h0, axi_wstrb, axi_wdata}, {28'h0, exp_w_q.pop_front()});
      end
      if (axi_arvalid && axi_arready) begin
        if (exp_ar_q.size() == 0) check("unexpected_ar", {32'h0, axi_araddr}, 64'h0);
        else check("araddr", {32'h0, axi_araddr}, {32'h0, exp_ar_q.pop_front()});
      end
      if (noc_wr) begin
        wr_cycles++;
        if (exp_resp_q.size() == 0) begin
          check("unexpected_resp", {22'h0, noc_din}, 64'h0);
        end else if (noc_wait) begin
          check("resp_hold", {22'h0, noc_din}, {22'h0, exp_resp_q[0].flit});
        end else begin
          cur = exp_resp_q.pop_front();
          check("resp_flit", {22'h0, noc_din}, {22'h0, cur.flit});
          check("resp_wr_cycles", wr_cycles, cur.cycles);
          wr_cycles = 0;
        end
      end
    end
  end

  // Presents one flit and returns 1 unit after the posedge that consumed it.
  task automatic send_flit(input logic [BUS-1:0] f);
    int n = 0;
    noc_dout = f;
    noc_nd   = 1'b1;
    forever begin
      @(negedge clk);
      if (noc_rd) break;
      n++;
      if (n > 200) begin
        check("rd_timeout", 64'(n), 64'd0);
        noc_nd = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    noc_nd = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size() + exp_resp_q.size()) != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500)
      check("txn_timeout", 64'(exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size() + exp_resp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    rst_n    = 1'b0;
    noc_nd   = 1'b1;
    noc_dout = {10'h3FF, 32'hFFFF_FFFF};

    // Reset: everything quiet, incoming flit not consumed even with nd high.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {57'h0, noc_rd, noc_wr, axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready}, 64'h0);
    check("reset_din", {22'h0, noc_din}, 64'h0);
    check("reset_addr", {axi_awaddr, axi_araddr}, 64'h0);
    check("reset_wdata", {28'h0, axi_wstrb, axi_wdata}, 64'h0);
    noc_nd = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Read OKAY from (1,0,2), also checks minimum 4-cycle latency.
    rdata_cfg = 32'h1234_5678; rresp_cfg = 2'b00;
    exp_ar_q.push_back(32'h0000_0040);
    exp_resp_q.push_back('{flit: resp_flit(1'b1, 1'b0, 3'd2, 32'h1234_5678), cycles: 1});
    send_flit(req_flit(1'b1, 1'b0, 3'd2, 32'h0000_0010));
    lat = 1;
    while (!noc_wr && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("read_latency", 64'(lat), 64'd4);
    wait_done();

    // Write OKAY, awready 3 cycles after wready.
    aw_delay = 3; w_delay = 0; bresp_cfg = 2'b00;
    exp_aw_q.push_back(32'h0000_000C);
    exp_w_q.push_back({4'hF, 32'hCAFE_F00D});
    exp_resp_q.push_back('{flit: resp_flit(1'b1, 1'b0, 3'd2, 32'h0), cycles: 1});
    send_flit(req_flit(1'b1, 1'b0, 3'd2, 32'h8F00_0003));
    send_flit(req_flit(1'b1, 1'b0, 3'd2, 32'hCAFE_F00D));
    wait_done();

    // Write SLVERR from (0,1,5), wready after awready, delayed bvalid.
    aw_delay = 0; w_delay = 2; b_delay = 1; bresp_cfg = 2'b10;
    exp_aw_q.push_back(32'h0000_0004);
    exp_w_q.push_back({4'h3, 32'h1122_3344});
    exp_resp_q.push_back('{flit: resp_flit(1'b0, 1'b1, 3'd5, 32'h0000_0002), cycles: 1});
    send_flit(req_flit(1'b0, 1'b1, 3'd5, 32'h8300_0001));
    send_flit(req_flit(1'b0, 1'b1, 3'd5, 32'h1122_3344));
    wait_done();
    w_delay = 0; b_delay = 0; bresp_cfg = 2'b00;

    // Read DECERR at the top word address -> error data word.
    ar_delay = 1; r_delay = 2; rdata_cfg = 32'h5555_5555; rresp_cfg = 2'b11;
    exp_ar_q.push_back(32'h03FF_FFFC);
    exp_resp_q.push_back('{flit: resp_flit(1'b1, 1'b0, 3'd2, 32'hDEAD_BEEF), cycles: 1});
    send_flit(req_flit(1'b1, 1'b0, 3'd2, 32'h00FF_FFFF));
    wait_done();

    // Read EXOKAY (rresp[1]=0) passes rdata through.
    ar_delay = 0; r_delay = 0; rdata_cfg = 32'h0F0F_1234; rresp_cfg = 2'b01;
    exp_ar_q.push_back(32'h0000_0000);
    exp_resp_q.push_back('{flit: resp_flit(1'b0, 1'b1, 3'd5, 32'h0F0F_1234), cycles: 1});
    send_flit(req_flit(1'b0, 1'b1, 3'd5, 32'h0000_0000));
    wait_done();

    // Router back-pressure: wait high 5 cycles, write completes on the 6th.
    wait_cfg = 5; rdata_cfg = 32'hA5A5_A5A5; rresp_cfg = 2'b00;
    exp_ar_q.push_back(32'h0000_0080);
    exp_resp_q.push_back('{flit: resp_flit(1'b0, 1'b1, 3'd5, 32'hA5A5_A5A5), cycles: 6});
    send_flit(req_flit(1'b0, 1'b1, 3'd5, 32'h0000_0020));
    wait_done();
    wait_cfg = 0;

    // Foreign flit in WDATA becomes the new (read) command; no AXI write.
    rdata_cfg = 32'h600D_CAFE;
    exp_ar_q.push_back(32'h0000_0020);
    exp_resp_q.push_back('{flit: resp_flit(1'b0, 1'b1, 3'd5, 32'h600D_CAFE), cycles: 1});
    send_flit(req_flit(1'b1, 1'b0, 3'd2, 32'h8F00_0004));
    send_flit(req_flit(1'b0, 1'b1, 3'd5, 32'h0000_0008));
    wait_done();

    // Reset during AW_W abandons the write without a response.
    aw_delay = 20; w_delay = 20;
    send_flit(req_flit(1'b1, 1'b0, 3'd2, 32'h8F00_0005));
    send_flit(req_flit(1'b1, 1'b0, 3'd2, 32'h0000_0077));
    n = 0;
    while (!axi_awvalid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("aw_w_reached", {63'h0, axi_awvalid & axi_wvalid}, 64'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("reset_mid_txn", {58'h0, axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready, noc_wr}, 64'h0);
    rst_n = 1'b1;
    aw_delay = 0; w_delay = 0;
    @(posedge clk); #1;

    // Next request after the abandoned one is served normally.
    rdata_cfg = 32'h0BAD_F00D;
    exp_ar_q.push_back(32'h0000_0024);
    exp_resp_q.push_back('{flit: resp_flit(1'b1, 1'b0, 3'd2, 32'h0BAD_F00D), cycles: 1});
    send_flit(req_flit(1'b1, 1'b0, 3'd2, 32'h0000_0009));
    wait_done();

    repeat (3) @(posedge clk);
    #1;
    check("leftover_expect", 64'(exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size() + exp_resp_q.size()), 64'd0);
    check("final_idle", {62'h0, noc_wr, axi_awvalid | axi_arvalid}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
